// File: rtl/instruction_fetch_if.sv
// Bundles the fetch-stage control, program-load and fetch outputs into one port.
// master: controller/loader side, slave: instruction_fetch.
interface instruction_fetch_if;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        valid;
    logic        fault;

    modport master (
        output stall, flush, branch_taken, branch_offset, jump,
        output imem_we, imem_addr, imem_wdata,
        input  pc, instruction, if_pc, if_pc_plus4, valid, fault
    );

    modport slave (
        input  stall, flush, branch_taken, branch_offset, jump,
        input  imem_we, imem_addr, imem_wdata,
        output pc, instruction, if_pc, if_pc_plus4, valid, fault
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, word-addressed instruction memory, IF register, redirects and range fault.
// Define FETCH_DELAY_SLOT_EN to keep the word after a taken redirect live (delay slot).
//
// state  | meaning
// BOOT   | no fetch; moves to RUN on the next edge
// RUN    | normal fetch
// HALT   | out-of-range fetch attempted; left only by rst
module instruction_fetch #(
    parameter int          IMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    instruction_fetch_if.slave bus
);
    localparam int          AW        = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam logic [31:0] WORDS_32  = 32'(IMEM_WORDS);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    state_t      r_state;
    logic [31:0] r_mem [IMEM_WORDS];
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_if_pc;
    logic        r_valid;
    logic        r_fault;

    logic [31:0] w_if_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_fetch_ok;
    logic        w_wr_ok;
    logic        w_jump_en;
    logic        w_branch_en;
    logic        w_slot_valid;
    logic        w_unused;

    assign w_if_pc_plus4 = r_if_pc + 32'd4;
    assign w_fetch_ok    = {2'b00, r_pc[31:2]} < WORDS_32;
    assign w_wr_ok       = {2'b00, bus.imem_addr[31:2]} < WORDS_32;
    assign w_jump_en     = bus.jump & r_valid;
    assign w_branch_en   = bus.branch_taken & r_valid;
    assign w_unused      = &{1'b0, bus.imem_addr[1:0]};

    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (w_jump_en)
            w_next_pc = {w_if_pc_plus4[31:28], r_instr[25:0], 2'b00};
        else if (w_branch_en)
            w_next_pc = w_if_pc_plus4 + (bus.branch_offset << 2);
    end

`ifdef FETCH_DELAY_SLOT_EN
    assign w_slot_valid = ~bus.flush;
`else
    // The word fetched alongside a taken redirect becomes a bubble.
    assign w_slot_valid = ~bus.flush & ~(w_jump_en | w_branch_en);
`endif

    // Program load; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.imem_we && w_wr_ok)
            r_mem[bus.imem_addr[AW+1:2]] <= bus.imem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_if_pc <= 32'd0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: r_state <= S_RUN;
                S_RUN: begin
                    if (!bus.stall) begin
                        if (!w_fetch_ok) begin
                            r_state <= S_HALT;
                            r_fault <= 1'b1;
                            r_valid <= 1'b0;
                        end else begin
                            r_instr <= r_mem[r_pc[AW+1:2]];
                            r_if_pc <= r_pc;
                            r_valid <= w_slot_valid;
                            r_pc    <= w_next_pc;
                        end
                    end
                end
                S_HALT: begin
                    r_valid <= 1'b0;
                    r_fault <= 1'b1;
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.instruction = r_instr;
    assign bus.if_pc       = r_if_pc;
    assign bus.if_pc_plus4 = w_if_pc_plus4;
    assign bus.valid       = r_valid;
    assign bus.fault       = r_fault;
endmodule
